packet_serializer: RTL

Frames a byte-oriented payload into a serial bit stream: preamble, access address, PDU and CRC-24. The output stream drives the whitening stage directly downstream, one bit per clock, via bit_out plus whiten_trigger. Payload bytes arrive over a valid/ready byte interface from the frame buffer. whiten_trigger is held continuously high over exactly the PDU and CRC bits, so that stage's LFSR advances once per bit and resets between packets.

---
 rtl/packet_serializer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/packet_serializer.sv
// packet_serializer: frames payload bytes as preamble | access address | PDU | CRC-24
// and emits them one bit per clock toward the whitening stage.
module packet_serializer #(
  parameter logic [7:0]  PREAMBLE    = 8'hAA,
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter logic [23:0] CRC_INIT    = 24'h555555
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] length,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       whiten_trigger,
  output logic       busy,
  output logic       done,
  output logic       underflow
);

  localparam logic [23:0] CRC_POLY = 24'h00065B;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ADDR  = 3'd2,
    PDU   = 3'd3,
    CRC   = 3'd4,
    DONE  = 3'd5,
    UFLOW = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [4:0]  bit_cnt_r;
  logic [7:0]  len_r;
  logic [7:0]  byte_cnt_r;
  logic [7:0]  acc_cnt_r;
  logic [7:0]  hold_r;
  logic        hold_valid_r;
  logic [7:0]  shift_r;
  logic [23:0] crc_r;

  logic        start_acc_s;
  logic        xfer_s;
  logic        byte_avail_s;
  logic        last_bit_s;
  logic        pdu_last_s;
  logic        load_s;

  function automatic logic [23:0] crc24_step(input logic [23:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[23];
    crc24_step = {crc[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
  endfunction

  // Handshake and boundary qualifiers shared by the FSM and datapath.
  always_comb begin
    start_acc_s  = start && ((state_r == IDLE) || (state_r == UFLOW));
    xfer_s       = data_valid && data_ready;
    // A byte handed over in the boundary cycle bypasses the holding register.
    byte_avail_s = hold_valid_r || xfer_s;
    pdu_last_s   = (byte_cnt_r == len_r);
    case (state_r)
      PRE:     last_bit_s = (bit_cnt_r == 5'd7);
      ADDR:    last_bit_s = (bit_cnt_r == 5'd31);
      PDU:     last_bit_s = (bit_cnt_r == 5'd7);
      CRC:     last_bit_s = (bit_cnt_r == 5'd23);
      default: last_bit_s = 1'b0;
    endcase
    load_s = last_bit_s && (state_nxt_s == PDU);
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, UFLOW: begin
        if (start) state_nxt_s = PRE;
        else       state_nxt_s = IDLE;
      end
      PRE: begin
        if (last_bit_s) state_nxt_s = ADDR;
        else            state_nxt_s = PRE;
      end
      ADDR, PDU: begin
        if (!last_bit_s)       state_nxt_s = state_r;
        else if (pdu_last_s)   state_nxt_s = CRC;
        else if (byte_avail_s) state_nxt_s = PDU;
        else                   state_nxt_s = UFLOW;
      end
      CRC: begin
        if (last_bit_s) state_nxt_s = DONE;
        else            state_nxt_s = CRC;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    bit_out        = 1'b0;
    bit_valid      = 1'b0;
    whiten_trigger = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    underflow      = 1'b0;
    data_ready     = 1'b0;
    case (state_r)
      PRE: begin
        bit_out   = PREAMBLE[bit_cnt_r[2:0]];
        bit_valid = 1'b1;
        busy      = 1'b1;
      end
      ADDR: begin
        bit_out   = ACCESS_ADDR[bit_cnt_r];
        bit_valid = 1'b1;
        busy      = 1'b1;
      end
      PDU: begin
        bit_out        = shift_r[0];
        bit_valid      = 1'b1;
        whiten_trigger = 1'b1;
        busy           = 1'b1;
      end
      CRC: begin
        bit_out        = crc_r[23];
        bit_valid      = 1'b1;
        whiten_trigger = 1'b1;
        busy           = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      UFLOW: begin
        underflow = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    if ((state_r == PRE) || (state_r == ADDR) || (state_r == PDU) || (state_r == CRC)) begin
      data_ready = !hold_valid_r && (acc_cnt_r < len_r);
    end else begin
      data_ready = 1'b0;
    end
  end

  // Bit position within the current field; restarts at every field or byte boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt_r <= 5'd0;
    end else if ((state_r == PRE) || (state_r == ADDR) || (state_r == PDU) || (state_r == CRC)) begin
      bit_cnt_r <= last_bit_s ? 5'd0 : (bit_cnt_r + 5'd1);
    end else begin
      bit_cnt_r <= 5'd0;
    end
  end

  // Byte buffer, counters and CRC register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_r        <= 8'd0;
      byte_cnt_r   <= 8'd0;
      acc_cnt_r    <= 8'd0;
      hold_r       <= 8'd0;
      hold_valid_r <= 1'b0;
      shift_r      <= 8'd0;
      crc_r        <= CRC_INIT;
    end else if (start_acc_s) begin
      len_r        <= length;
      byte_cnt_r   <= 8'd0;
      acc_cnt_r    <= 8'd0;
      hold_valid_r <= 1'b0;
      crc_r        <= CRC_INIT;
    end else begin
      if (xfer_s) acc_cnt_r <= acc_cnt_r + 8'd1;
      if (load_s) begin
        shift_r      <= hold_valid_r ? hold_r : data_in;
        hold_valid_r <= 1'b0;
        byte_cnt_r   <= byte_cnt_r + 8'd1;
      end else begin
        if (state_r == PDU) shift_r <= {1'b0, shift_r[7:1]};
        if (xfer_s) begin
          hold_r       <= data_in;
          hold_valid_r <= 1'b1;
        end
      end
      if (state_r == PDU)      crc_r <= crc24_step(crc_r, shift_r[0]);
      else if (state_r == CRC) crc_r <= {crc_r[22:0], 1'b0};
    end
  end

endmodule
